// File: rtl/gpio_mux_guarded_wb.sv
// Wishbone-controlled GPIO ownership multiplexer. Each pad is routed to one
// of NUM_TEAMS+1 design sources; any change of owner parks the pad in high-Z
// for GUARD_CYCLES cycles so two designs never drive it back-to-back.
module gpio_mux_guarded_wb #(
    parameter int          NUM_TEAMS    = 12,
    parameter int          NUM_PINS     = 38,
    parameter int          SEL_W        = 4,
    parameter int          GUARD_CYCLES = 4,
    parameter logic [31:0] BASE_ADDR    = 32'h3000_0000
) (
    input  logic                              wb_clk_i,
    input  logic                              wb_rst_i,
    input  logic                              wbs_stb_i,
    input  logic                              wbs_cyc_i,
    input  logic                              wbs_we_i,
    input  logic [3:0]                        wbs_sel_i,
    input  logic [31:0]                       wbs_dat_i,
    input  logic [31:0]                       wbs_adr_i,
    output logic                              wbs_ack_o,
    output logic [31:0]                       wbs_dat_o,
    input  logic [NUM_PINS*(NUM_TEAMS+1)-1:0] designs_gpio_out_flat,
    input  logic [NUM_PINS*(NUM_TEAMS+1)-1:0] designs_gpio_oeb_flat,
    output logic [NUM_PINS-1:0]               gpio_out,
    output logic [NUM_PINS-1:0]               gpio_oeb
);

    localparam int                NUM_SRC     = NUM_TEAMS + 1;
    localparam int                SRC_SLOTS   = 2 ** SEL_W;
    localparam int                CNT_W       = $clog2(GUARD_CYCLES) + 1;
    localparam logic [CNT_W-1:0]  GUARD_LOAD  = CNT_W'(GUARD_CYCLES - 1);
    localparam logic [29:0]       STATUS_WORD = 30'h40;
    localparam logic [29:0]       LOCK_WORD   = 30'h41;
    // STATUS is a single 32-bit word, so only the first 32 pins are visible
    // there; every pin's busy flag is also in bit 31 of its SELECT word.
    localparam int                STATUS_BITS = (NUM_PINS < 32) ? NUM_PINS : 32;

    typedef enum logic {ST_ACTIVE, ST_GUARD} pin_state_e;

    pin_state_e       state_q   [NUM_PINS];
    logic [SEL_W-1:0] owner_q   [NUM_PINS];
    logic [SEL_W-1:0] pending_q [NUM_PINS];
    logic [CNT_W-1:0] cnt_q     [NUM_PINS];
    logic             lock_q;
    logic             ack_q;
    logic [31:0]      rdata_q, rdata_d;
    logic [NUM_PINS-1:0] out_q, oeb_q, out_d, oeb_d, busy, pin_wr;

    // Sources padded to every encodable select value; unused slots look like
    // a released pad, which is exactly how an invalid owner must behave.
    logic [NUM_PINS-1:0] src_out [SRC_SLOTS];
    logic [NUM_PINS-1:0] src_oeb [SRC_SLOTS];

    for (genvar s = 0; s < SRC_SLOTS; s++) begin : g_src
        if (s < NUM_SRC) begin : g_used
            assign src_out[s] = designs_gpio_out_flat[s*NUM_PINS +: NUM_PINS];
            assign src_oeb[s] = designs_gpio_oeb_flat[s*NUM_PINS +: NUM_PINS];
        end else begin : g_unused
            assign src_out[s] = '0;
            assign src_oeb[s] = '1;
        end
    end

    // Bus decode: a request is only seen while ack is low, which both limits
    // ack to one cycle and forces a dead cycle between transactions.
    logic [31:0]      offset;
    logic [29:0]      word_idx;
    logic             req, wr, sel_hit, sel_wr, lock_wr;
    logic [SEL_W-1:0] wr_val;
    logic             unused_bits;

    assign offset      = wbs_adr_i - BASE_ADDR;
    assign word_idx    = offset[31:2];
    assign req         = wbs_stb_i & wbs_cyc_i & ~ack_q;
    assign wr          = req & wbs_we_i;
    assign sel_hit     = (word_idx < 30'(NUM_PINS));
    assign sel_wr      = wr & sel_hit & wbs_sel_i[0] & ~lock_q;
    assign lock_wr     = wr & (word_idx == LOCK_WORD) & wbs_dat_i[0];
    assign wr_val      = wbs_dat_i[SEL_W-1:0];
    assign unused_bits = ^{wbs_sel_i[3:1], wbs_dat_i[31:SEL_W], offset[1:0]};

    // Per-pin write strobes, busy flags and next pad values.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        pin_wr = '0;
        busy   = '0;
        out_d  = '0;
        oeb_d  = '1;
        for (int p = 0; p < NUM_PINS; p++) begin
            pin_wr[p] = sel_wr && (word_idx == 30'(p));
            busy[p]   = (state_q[p] == ST_GUARD);
            if (state_q[p] == ST_ACTIVE) begin
                out_d[p] = src_out[owner_q[p]][p];
                oeb_d[p] = src_oeb[owner_q[p]][p];
            end
        end
    end

    // Read data for the current request, registered so it is valid with ack.
    always_comb begin
        rdata_d = '0;
        if (sel_hit) begin
            for (int p = 0; p < NUM_PINS; p++) begin
                if (word_idx == 30'(p)) begin
                    rdata_d[SEL_W-1:0] = pending_q[p];
                    rdata_d[31]        = busy[p];
                end
            end
        end else if (word_idx == STATUS_WORD) begin
            for (int p = 0; p < STATUS_BITS; p++) begin
                rdata_d[p] = busy[p];
            end
        end else if (word_idx == LOCK_WORD) begin
            rdata_d[0] = lock_q;
        end
    end

    // Wishbone response and registered pad outputs.
    always_ff @(posedge wb_clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (wb_rst_i) begin
            ack_q   <= 1'b0;
            rdata_q <= '0;
            out_q   <= '0;
            oeb_q   <= '1;
        end else begin
            ack_q   <= req;
            rdata_q <= (req && !wbs_we_i) ? rdata_d : '0;
            out_q   <= out_d;
            oeb_q   <= oeb_d;
        end
    end

    // Lock bit and the per-pin ownership FSMs (ACTIVE / GUARD).
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            // NOTE: these arrays are small per-pin flop banks, not RAM, so
            // resetting every entry is intended and cheap.
            for (int p = 0; p < NUM_PINS; p++) begin
                state_q[p]   <= ST_ACTIVE;
                owner_q[p]   <= '0;
                pending_q[p] <= '0;
                cnt_q[p]     <= '0;
            end
            lock_q <= 1'b0;
        end else begin
            if (lock_wr) begin
                lock_q <= 1'b1;
            end
            for (int p = 0; p < NUM_PINS; p++) begin
                case (state_q[p])
                    ST_ACTIVE: begin
                        if (pin_wr[p]) begin
                            pending_q[p] <= wr_val;
                            if (wr_val != owner_q[p]) begin
                                cnt_q[p]   <= GUARD_LOAD;
                                state_q[p] <= ST_GUARD;
                            end
                        end
                    end
                    ST_GUARD: begin
                        if (pin_wr[p]) begin
                            // Any write during a guard restarts it, even one
                            // back to the current owner.
                            pending_q[p] <= wr_val;
                            cnt_q[p]     <= GUARD_LOAD;
                        end else if (cnt_q[p] == '0) begin
                            owner_q[p] <= pending_q[p];
                            state_q[p] <= ST_ACTIVE;
                        end else begin
                            cnt_q[p] <= cnt_q[p] - CNT_W'(1);
                        end
                    end
                    default: state_q[p] <= ST_ACTIVE;
                endcase
            end
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = rdata_q;
    assign gpio_out  = out_q;
    assign gpio_oeb  = oeb_q;

endmodule

// File: doc/gpio_mux_guarded_wb.md
Name: gpio_mux_guarded_wb

Overview:
- Wishbone-slave GPIO ownership multiplexer.
- Routes each of NUM_PINS caravel GPIOs to one of NUM_TEAMS+1 design sources, selected per pin by a programmable select register.
- On every ownership change, the pin is forced to high-Z for a guard interval before the new owner drives it, so two designs never drive the pin back-to-back.
- Adds a sticky lock bit and per-pin busy status; sits between the team designs and the user-project GPIO pads.

Parameters:
- NUM_TEAMS, 12, number of team designs; source 0 is the default/management design, so sources are 0..NUM_TEAMS.
- NUM_PINS, 38, number of GPIO pins controlled.
- SEL_W, 4, select field width; 2^SEL_W must be >= NUM_TEAMS+1.
- GUARD_CYCLES, 4, high-Z cycles inserted on an owner change; must be >= 1.
- BASE_ADDR, 32'h3000_0000, register base address.

Ports:
- wb_clk_i  in  1  sole clock.
- wb_rst_i  in  1  synchronous, active-high reset.
- wbs_stb_i  in  1  WB strobe.
- wbs_cyc_i  in  1  WB cycle.
- wbs_we_i  in  1  WB write enable.
- wbs_sel_i  in  4  WB byte selects.
- wbs_dat_i  in  32  WB write data.
- wbs_adr_i  in  32  WB address.
- wbs_ack_o  out  1  WB acknowledge.
- wbs_dat_o  out  32  WB read data.
- designs_gpio_out_flat  in  NUM_PINS*(NUM_TEAMS+1)  source s, pin p at bit s*NUM_PINS+p.
- designs_gpio_oeb_flat  in  NUM_PINS*(NUM_TEAMS+1)  active-low output enables, same packing as designs_gpio_out_flat.
- gpio_out  out  NUM_PINS  muxed pin outputs.
- gpio_oeb  out  NUM_PINS  muxed active-low output enables.

Behaviour:
- One clock, wb_clk_i; reset wb_rst_i is synchronous and active-high.

Reset values:
- wbs_ack_o=0, wbs_dat_o=0, gpio_out=0, gpio_oeb=all 1s.
- Every pin: owner=0, pending=0, state ACTIVE.
- lock=0.

Register map (word addresses; offsets in bytes):
- BASE+4*p, p<NUM_PINS: SELECT[p].
  - Write: pending select from wbs_dat_i[SEL_W-1:0], applied only if wbs_sel_i[0]=1.
  - Read: [SEL_W-1:0]=pending, [31]=busy (state GUARD), other bits 0.
- BASE+0x100: STATUS, read-only; bit p = busy[p].
- BASE+0x104: LOCK.
  - Writing 1 to bit 0 sets lock; lock clears only on reset.
  - Read returns lock in bit 0.
- Any other address: reads 0, writes ignored, still acked.

WB handshake:
- A request is stb&cyc with ack=0.
- The slave asserts ack for exactly 1 cycle, the cycle after the request; read data is valid with ack.
- ack is forced low for the cycle after an ack, so the minimum spacing between transactions is 2 cycles.
- The write takes effect on the ack cycle edge.

Per-pin FSM (NUM_PINS independent instances, each with a guard counter of width clog2(GUARD_CYCLES)+1):
- ACTIVE:
  - A SELECT[p] write with value != owner and lock=0: pending<=value, cnt<=GUARD_CYCLES-1, go to GUARD.
  - A write with value == owner: pending<=value, stay ACTIVE, no glitch.
- GUARD:
  - Pin is forced to gpio_out=0, gpio_oeb=1.
  - A new SELECT write with lock=0: pending<=value, cnt<=GUARD_CYCLES-1, restart the guard. This applies even if value equals the old owner.
  - cnt==0: owner<=pending, go to ACTIVE.
- Lock=1: SELECT writes are acked but change nothing, including pending. A guard already in progress completes normally.
- Owner value > NUM_TEAMS is invalid: the pin is held at out=0, oeb=1 while ACTIVE.

Output path:
- gpio_out and gpio_oeb are registered.
- Pin p reflects the owner's inputs with 1-cycle latency: pad[t+1] = design[owner](t).
- A guard of GUARD_CYCLES cycles appears on the pads one cycle after the write edge.

Reset mid-guard: all pins return to owner 0, ACTIVE, oeb=1 on the reset cycle; source 0 drives from the following cycle.

Test Plan:
- Reset, then drive source 0 out=all 1s, oeb=all 0s → gpio_oeb=0, gpio_out=1 on all pins from the cycle after reset deasserts; wbs_ack_o=0 throughout idle.
- Write SELECT[5]=3 (GUARD_CYCLES=4), source 3 pin 5 out=1/oeb=0, source 0 out=0/oeb=0 → pin 5 oeb=1 for exactly 4 cycles, then out=1/oeb=0; busy bit 5 reads 1 mid-guard and 0 after.
- Write SELECT[5]=3 a second time with pin 5 already owned by 3 → no oeb pulse; readback = 0x0000_0003.
- Write SELECT[7]=2, then SELECT[7]=4 two cycles later → guard restarts; pin 7 is high-Z 4 cycles after the second write, then follows source 4; source 2 never reaches the pad.
- Write LOCK=1, then SELECT[0]=9 → ack received, pin 0 unchanged, SELECT[0] reads the old value; reads of 0x104 return 1 until reset.
- Write SELECT[2]=15 with NUM_TEAMS=12 → after guard, pin 2 stays oeb=1/out=0. Read BASE+0x200 → 0 with one-cycle ack. Assert reset mid-guard → all owners 0, oeb=1 on the reset cycle.
